// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack / mantissa product / round+pack) with whole-pipe stall.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.

module multiplier_nbit #(
    parameter int N         = 24,
    parameter int IMPL_TYPE = 0
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);
    generate
        if (IMPL_TYPE == 0) begin : g_direct
            assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};
        end else begin : g_shift_add
            logic [2*N-1:0] w_acc;
            // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
            always_comb begin
                w_acc = '0;
                for (int i = 0; i < N; i++) begin
                    if (i_b[i]) w_acc = w_acc + ({{N{1'b0}}, i_a} << i);
                end
            end
            assign o_p = w_acc;
        end
    endgenerate
endmodule

module fp_mul_pipe #(
    parameter int EXP_W     = 8,
    parameter int MAN_W     = 23,
    parameter int TAG_W     = 4,
    parameter int IMPL_TYPE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int M    = MAN_W + 1;
    localparam int EW2  = EXP_W + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [1:0] K_NUM  = 2'd0;
    localparam logic [1:0] K_NAN  = 2'd1;
    localparam logic [1:0] K_INF  = 2'd2;
    localparam logic [1:0] K_ZERO = 2'd3;

    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // ---------------- S1: unpack and classify ----------------
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_inf_x_zero, w_invalid;
    logic [1:0]       w_kind;
    logic [EW2-1:0]   w_esum;

    assign w_ea = in_a[W-2 -: EXP_W];
    assign w_eb = in_b[W-2 -: EXP_W];
    assign w_fa = in_a[MAN_W-1:0];
    assign w_fb = in_b[MAN_W-1:0];

    // Exponent 0 covers subnormals too: they are flushed to zero here.
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);

    assign w_inf_x_zero = (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
    assign w_invalid    = w_inf_x_zero | (w_a_nan & ~w_fa[MAN_W-1]) | (w_b_nan & ~w_fb[MAN_W-1]);
    assign w_esum       = EW2'(w_ea) + EW2'(w_eb) - EW2'(BIAS);

    always_comb begin
        w_kind = K_NUM;
        if (w_a_nan | w_b_nan | w_inf_x_zero) w_kind = K_NAN;
        else if (w_a_inf | w_b_inf)           w_kind = K_INF;
        else if (w_a_zero | w_b_zero)         w_kind = K_ZERO;
    end

    logic             r1_valid, r1_sign, r1_invalid;
    logic [1:0]       r1_kind;
    logic [EW2-1:0]   r1_esum;
    logic [M-1:0]     r1_ma, r1_mb;
    logic [TAG_W-1:0] r1_tag;

    // ---------------- S2: mantissa product ----------------
    logic [2*M-1:0] w_prod;

    multiplier_nbit #(.N(M), .IMPL_TYPE(IMPL_TYPE)) u_mul (
        .i_a (r1_ma),
        .i_b (r1_mb),
        .o_p (w_prod)
    );

    logic             r2_valid, r2_sign, r2_invalid;
    logic [1:0]       r2_kind;
    logic [EW2-1:0]   r2_esum;
    logic [2*M-1:0]   r2_prod;
    logic [TAG_W-1:0] r2_tag;

    // ---------------- S3: normalise, round, pack ----------------
    logic             w_msb, w_guard, w_sticky, w_rup, w_carry, w_ovf, w_unf;
    logic [2*M-2:0]   w_pn;
    logic [MAN_W-1:0] w_frac;
    logic [MAN_W:0]   w_frac_r;
    logic [EW2-1:0]   w_exp;
    logic [W-1:0]     w_result;
    logic [3:0]       w_flags;

    // Product of two [1,2) mantissas lies in [1,4): at most one position of normalisation.
    assign w_msb    = r2_prod[2*M-1];
    assign w_pn     = w_msb ? r2_prod[2*M-2:0] : {r2_prod[2*M-3:0], 1'b0};
    assign w_frac   = w_pn[2*M-2 -: MAN_W];
    assign w_guard  = w_pn[M-1];
    assign w_sticky = |w_pn[M-2:0];
`ifdef FP_MUL_RNE_EN
    assign w_rup    = w_guard & (w_sticky | w_frac[0]);
`else
    assign w_rup    = 1'b0;
`endif
    assign w_frac_r = {1'b0, w_frac} + (MAN_W+1)'(w_rup);
    assign w_carry  = w_frac_r[MAN_W];
    assign w_exp    = r2_esum + EW2'(w_msb) + EW2'(w_carry);
    assign w_ovf    = ~w_exp[EW2-1] && (w_exp[EW2-2:0] >= (EW2-1)'((1 << EXP_W) - 1));
    assign w_unf    = w_exp[EW2-1] || (w_exp == '0);

    always_comb begin
        w_result = {r2_sign, w_exp[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
        w_flags  = {3'b000, w_guard | w_sticky};
        case (r2_kind)
            K_NAN: begin
                w_result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                w_flags  = {r2_invalid, 3'b000};
            end
            K_INF: begin
                w_result = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_flags  = 4'b0000;
            end
            K_ZERO: begin
                w_result = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
                w_flags  = 4'b0000;
            end
            default: begin
                if (w_ovf) begin
`ifdef FP_MUL_RNE_EN
                    w_result = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
                    w_result = {r2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
                    w_flags  = 4'b0101;
                end else if (w_unf) begin
                    w_result = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
                    w_flags  = 4'b0011;
                end
            end
        endcase
    end

    logic             r3_valid;
    logic [W-1:0]     r3_result;
    logic [TAG_W-1:0] r3_tag;
    logic [3:0]       r3_flags;

    // NOTE: sequential state uses non-blocking '<=' so every stage samples the pre-edge values of the one before.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0; r1_sign <= 1'b0; r1_invalid <= 1'b0; r1_kind <= K_NUM;
            r1_esum  <= '0;   r1_ma   <= '0;   r1_mb      <= '0;   r1_tag  <= '0;
            r2_valid <= 1'b0; r2_sign <= 1'b0; r2_invalid <= 1'b0; r2_kind <= K_NUM;
            r2_esum  <= '0;   r2_prod <= '0;   r2_tag     <= '0;
            r3_valid <= 1'b0; r3_result <= '0; r3_tag <= '0; r3_flags <= '0;
        end else if (w_adv) begin
            // Valids shift as one so a bubble keeps its slot while the pipe is stalled.
            r1_valid <= in_valid;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
            if (in_valid) begin
                r1_sign    <= in_a[W-1] ^ in_b[W-1];
                r1_invalid <= w_invalid;
                r1_kind    <= w_kind;
                r1_esum    <= w_esum;
                r1_ma      <= {1'b1, w_fa};
                r1_mb      <= {1'b1, w_fb};
                r1_tag     <= in_tag;
            end
            if (r1_valid) begin
                r2_sign    <= r1_sign;
                r2_invalid <= r1_invalid;
                r2_kind    <= r1_kind;
                r2_esum    <= r1_esum;
                r2_prod    <= w_prod;
                r2_tag     <= r1_tag;
            end
            if (r2_valid) begin
                r3_result  <= w_result;
                r3_tag     <= r2_tag;
                r3_flags   <= w_flags;
            end
        end
    end

    assign out_valid  = r3_valid;
    assign out_result = r3_result;
    assign out_tag    = r3_tag;
    assign out_flags  = r3_flags;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (binary32): directed vectors pushed at issue, popped by a monitor.
// Expected values follow FP_MUL_RNE_EN when it is defined, truncation otherwise.

module tb_fp_mul_pipe;
    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [3:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag, out_flags;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_ready = 1'b0;

`ifdef FP_MUL_RNE_EN
    localparam logic [31:0] OVF_RES = 32'h7F800000;
    localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
    localparam logic [31:0] OVF_RES = 32'h7F7FFFFF;
    localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4), .IMPL_TYPE(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] res, input logic [3:0] flags);
        exp_t e;
        bit   acc;
        e.res = res; e.tag = tag; e.flags = flags;
        sb.push_back(e);
        in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL issue_timeout: tag %0h never accepted", tag);
    endtask

    task automatic drain();
        for (int n = 0; n < 500 && sb.size() != 0; n++) tick();
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) tick();
    endtask

    // Monitor: retire on handshake, and police hold-while-stalled and in_ready under stall.
    initial begin
        exp_t        e;
        bit          prev_stall = 1'b0;
        logic [39:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(out_valid), 64'(1));
                    check("hold_data", 64'({out_result, out_tag, out_flags}), 64'(prev_data));
                end
                if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(0));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_output: got %h tag %h, expected none", out_result, out_tag);
                    end else begin
                        e = sb.pop_front();
                        check("result", 64'(out_result), 64'(e.res));
                        check("tag",    64'(out_tag),    64'(e.tag));
                        check("flags",  64'(out_flags),  64'(e.flags));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = {out_result, out_tag, out_flags};
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid),  64'(0));
        check("rst_result",    64'(out_result), 64'(0));
        check("rst_tag",       64'(out_tag),    64'(0));
        check("rst_flags",     64'(out_flags),  64'(0));
        check("rst_in_ready",  64'(in_ready),   64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1.5 x 2.0 = 3.0, with latency measured from the accepting edge.
        issue(32'h3FC00000, 32'h40000000, 4'h1, 32'h40400000, 4'b0000);
        check("lat_edge1", 64'(out_valid), 64'(0));
        tick();
        check("lat_edge2", 64'(out_valid), 64'(0));
        tick();
        check("lat_edge3", 64'(out_valid), 64'(1));
        drain();

        // Boundary cases back-to-back.
        issue(32'h7F800000, 32'h00000000, 4'h2, 32'h7FC00000, 4'b1000);
        issue(32'h7F000000, 32'h7F000000, 4'h3, OVF_RES,      4'b0101);
        issue(32'h3F800001, 32'h3FC00000, 4'h4, TIE_RES,      4'b0001);
        issue(32'h00800000, 32'h00800000, 4'h5, 32'h00000000, 4'b0011);
        issue(32'h00000001, 32'h3F800000, 4'h6, 32'h00000000, 4'b0000);
        drain();

        // Tagged stream under random backpressure.
        rand_ready = 1'b1;
        issue(32'h3F800000, 32'h40490FDB, 4'h0, 32'h40490FDB, 4'b0000);
        issue(32'hC0000000, 32'h40400000, 4'h1, 32'hC0C00000, 4'b0000);
        issue(32'h3F000000, 32'h3F000000, 4'h2, 32'h3E800000, 4'b0000);
        issue(32'h7F800000, 32'hBF800000, 4'h3, 32'hFF800000, 4'b0000);
        issue(32'h7FC00000, 32'h3F800000, 4'h4, 32'h7FC00000, 4'b0000);
        issue(32'h7F800001, 32'h3F800000, 4'h5, 32'h7FC00000, 4'b1000);
        issue(32'h80000000, 32'h40000000, 4'h6, 32'h80000000, 4'b0000);
        issue(32'h3F800001, 32'h3F800001, 4'h7, 32'h3F800002, 4'b0001);
        drain();

        // Reset with three operations stalled in the pipe.
        out_ready = 1'b0;
        issue(32'h40400000, 32'h40400000, 4'hA, 32'h41100000, 4'b0000);
        issue(32'h40000000, 32'h40400000, 4'hB, 32'h40C00000, 4'b0000);
        issue(32'h3F800000, 32'h3F800000, 4'hC, 32'h3F800000, 4'b0000);
        check("full_out_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", 64'(out_valid),  64'(0));
        check("arst_result",    64'(out_result), 64'(0));
        check("arst_tag",       64'(out_tag),    64'(0));
        check("arst_flags",     64'(out_flags),  64'(0));
        check("arst_in_ready",  64'(in_ready),   64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        issue(32'h40000000, 32'h40000000, 4'h9, 32'h40800000, 4'b0000);
        drain();
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes on both sides. It is the successor to the single-precision combinational multiplier:
- exponent and mantissa widths are configurable (defaults give binary32);
- it adds correct rounding, exception flags and a pass-through tag;
- it sits between an operand-issue queue and a result writeback port, and may be stalled by either.

## Interface
- `EXP_W`, 8, exponent field width (≥ 4)
- `MAN_W`, 23, stored fraction width (≥ 4)
- `TAG_W`, 4, sideband tag width carried with each operation
- `IMPL_TYPE`, 0, forwarded to the internal `multiplier_nbit` instance

- `clk` input 1: clock, all state on the rising edge
- `rst_n` input 1: reset, asynchronous, active-low
- `in_valid` input 1: operands present
- `in_ready` output 1: block accepts operands this cycle
- `in_a`, `in_b` input 1+EXP_W+MAN_W: operands
- `in_tag` input TAG_W: sideband, returned unchanged
- `out_valid` output 1: result present
- `out_ready` input 1: consumer accepts result
- `out_result` output 1+EXP_W+MAN_W: product
- `out_tag` output TAG_W: tag of this result
- `out_flags` output 4: {invalid, overflow, underflow, inexact}

## Operation
- Pipeline stages:
  - S1: unpack, classify operands (zero/inf/NaN/normal) and compute the exponent sum.
  - S2: (MAN_W+1)×(MAN_W+1) mantissa product via `multiplier_nbit`.
  - S3: normalise, round, detect overflow/underflow and pack.
  - Each stage has a valid bit; data registers load only when that stage advances.
- Subnormals are flushed to zero:
  - An input with exponent 0 is treated as ±0.
  - Any result whose biased exponent is ≤ 0 after rounding becomes ±0 with underflow=1 and inexact=1.
- Sign is `a.sign ^ b.sign` for every non-NaN result.
- Exponent arithmetic is done in EXP_W+2 bits, signed: e = ea + eb − (2^(EXP_W−1)−1) + p_msb + round_carry.
- Overflow: e ≥ 2^EXP_W−1 → ±inf, overflow=1, inexact=1.
- Special cases, in priority order:
  1. Either operand NaN, or inf×0 → canonical quiet NaN (sign 0, exp all ones, fraction MSB 1, rest 0). invalid=1 only for inf×0 or a signalling NaN input (fraction MSB 0).
  2. Either operand inf → ±inf, no flags.
  3. Either operand zero → ±0, no flags.
- inexact=1 whenever any discarded product bit is non-zero.

## Timing
- Latency is 3 cycles from input handshake to `out_valid` when unstalled; throughput is 1 per cycle.
- The pipeline stalls as a whole:
  - advance = `~out_valid | out_ready`, and `in_ready` = advance (combinational from `out_ready`).
  - A bubble does not collapse under stall.
- While `out_valid`=1 and `out_ready`=0, `out_result`, `out_tag` and `out_flags` are held stable.
- Simultaneous input accept and output accept in the same cycle is legal; no data is lost or duplicated.
- Reset (asynchronous, mid-operation included): all stage valids clear, `out_valid`=0, `out_result`/`out_tag`/`out_flags`=0. `in_ready`=1 out of reset. In-flight operations are discarded.

## Configuration
- `FP_MUL_RNE_EN` defined: round-to-nearest, ties-to-even, using guard and sticky bits. Mantissa overflow from rounding renormalises, increments e, and is rechecked against overflow.
- Not defined: round toward zero (truncation). round_carry is always 0; inexact is still reported; overflow returns the largest finite value instead of inf (flags unchanged).

## Test plan
- 0x3FC00000 × 0x40000000, out_ready=1 → 0x40400000, flags 0, `out_valid` exactly 3 cycles after accept.
- 0x7F800000 × 0x00000000 → 0x7FC00000, flags invalid=1. Then 0x7F000000 × 0x7F000000 → 0x7F800000 with overflow=1, inexact=1 (0x7F7FFFFF without RNE).
- Tie case 0x3F800001 × 0x3FC00000 → 0x3FC00002, inexact=1 with `FP_MUL_RNE_EN`; 0x3FC00001 without.
- 0x00800000 × 0x00800000 → 0x00000000, underflow=1, inexact=1. Denormal 0x00000001 × 0x3F800000 → 0x00000000, no flags.
- Back-to-back stream of 8 ops with tags 0..7 while out_ready toggles randomly → results arrive in order with matching tags and none are dropped or duplicated; `in_ready` low whenever `out_valid & ~out_ready`.
- Assert `rst_n`=0 with 3 ops in flight → all outputs 0 immediately; after release, a new op 0x40000000 × 0x40000000 → 0x40800000 with no stale outputs.
